// File: rtl/rom_dl_sequencer.sv
// Routes ROM download bytes to two SDRAM ports, on-chip ROM strobes, or DIP registers.
// Latency: SDRAM write returns to idle 3 cycles after the event with immediate ack; dl_wr/dip update next cycle.
// Backpressure: ioctl_wait held while an SDRAM write is in flight; strobes arriving while busy are dropped and flagged.
module rom_dl_sequencer #(
    parameter logic [16:0] CPU_END = 17'h0A000,
    parameter logic [16:0] SP_BASE = 17'h10000,
    parameter logic [16:0] SP_END  = 17'h1C000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        port1_req,
    output logic        port2_req,
    input  logic        port1_ack,
    input  logic        port2_ack,
    output logic [22:0] port1_a,
    output logic [22:0] port2_a,
    output logic [1:0]  port1_ds,
    output logic [1:0]  port2_ds,
    output logic [15:0] port1_d,
    output logic [15:0] port2_d,
    output logic        dl_wr,
    output logic [7:0]  dip_sw0,
    output logic [7:0]  dip_sw1,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t      state;
    logic        wr_prev;
    logic        tgt2;
    logic        wr_evt;
    logic        idx0;
    logic        is_p1;
    logic        is_p2;
    logic        is_dip;
    logic        sdram_hit;
    logic        ack_done;
    logic [23:0] sp_off;

    assign wr_evt    = ioctl_download & ioctl_wr & ~wr_prev;
    assign idx0      = (ioctl_index == 8'd0);
    assign is_p1     = idx0 && (ioctl_addr < {8'd0, CPU_END});
    assign is_p2     = idx0 && (ioctl_addr >= {8'd0, SP_BASE}) && (ioctl_addr < {8'd0, SP_END});
    assign is_dip    = (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);
    assign sdram_hit = is_p1 | is_p2;
    // Sprite offset only matters inside the sprite window, where bit 24 is always clear.
    assign sp_off    = ioctl_addr[23:0] - {7'd0, SP_BASE};
    assign ack_done  = tgt2 ? (port2_ack == port2_req) : (port1_ack == port1_req);

    // Raised combinationally on the event cycle so the host stalls before the next byte.
    assign ioctl_wait = (state != IDLE) || (wr_evt && sdram_hit);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            wr_prev   <= 1'b0;
            tgt2      <= 1'b0;
            port1_req <= 1'b0;
            port2_req <= 1'b0;
            port1_a   <= '0;
            port2_a   <= '0;
            port1_ds  <= '0;
            port2_ds  <= '0;
            port1_d   <= '0;
            port2_d   <= '0;
            dl_wr     <= 1'b0;
            dip_sw0   <= 8'h00;
            dip_sw1   <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            wr_prev <= ioctl_wr;
            dl_wr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_evt) begin
                        if (is_p1) begin
                            port1_a  <= ioctl_addr[23:1];
                            port1_ds <= {ioctl_addr[0], ~ioctl_addr[0]};
                            port1_d  <= {ioctl_dout, ioctl_dout};
                            tgt2     <= 1'b0;
                            state    <= ISSUE;
                        end else if (is_p2) begin
                            port2_a  <= {sp_off[23:16], sp_off[13:0], sp_off[15]};
                            port2_ds <= {sp_off[14], ~sp_off[14]};
                            port2_d  <= {ioctl_dout, ioctl_dout};
                            tgt2     <= 1'b1;
                            state    <= ISSUE;
                        end else if (is_dip) begin
                            if (ioctl_addr[2:0] == 3'd0) dip_sw0 <= ioctl_dout;
                            if (ioctl_addr[2:0] == 3'd1) dip_sw1 <= ioctl_dout;
                        end else if (idx0) begin
                            dl_wr <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (tgt2) port2_req <= ~port2_req;
                    else      port1_req <= ~port1_req;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (wr_evt && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: SDRAM routing, inline writes, overrun and reset recovery.
module tb_rom_dl_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        port1_req, port2_req;
    logic        port1_ack, port2_ack;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        dl_wr;
    logic [7:0]  dip_sw0, dip_sw1;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    rom_dl_sequencer dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .port1_req      (port1_req),
        .port2_req      (port2_req),
        .port1_ack      (port1_ack),
        .port2_ack      (port2_ack),
        .port1_a        (port1_a),
        .port2_a        (port2_a),
        .port1_ds       (port1_ds),
        .port2_ds       (port2_ds),
        .port1_d        (port1_d),
        .port2_d        (port2_d),
        .dl_wr          (dl_wr),
        .dip_sw0        (dip_sw0),
        .dip_sw1        (dip_sw1),
        .overrun        (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dat);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = dat;
        ioctl_wr    = 1'b1;
    endtask

    initial begin
        reset = 1'b1; ioctl_download = 1'b1; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        port1_ack = 1'b0; port2_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_req1", 32'(port1_req), 0);
        chk("rst_req2", 32'(port2_req), 0);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_dlwr", 32'(dl_wr), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_dip", {16'd0, dip_sw1, dip_sw0}, 0);
        chk("rst_p1a", 32'(port1_a), 0);
        chk("rst_p2a", 32'(port2_a), 0);

        // port1 write, ack two cycles after the toggle
        drive(8'd0, 25'h00003, 8'hA5);
        #1 chk("p1_wait_evt", 32'(ioctl_wait), 1);
        step();
        ioctl_wr = 1'b0;
        chk("p1_wait_issue", 32'(ioctl_wait), 1);
        chk("p1_req_pre", 32'(port1_req), 0);
        step();
        chk("p1_req", 32'(port1_req), 1);
        chk("p1_req2", 32'(port2_req), 0);
        chk("p1_a", 32'(port1_a), 32'h000001);
        chk("p1_ds", 32'(port1_ds), 32'b10);
        chk("p1_d", 32'(port1_d), 32'hA5A5);
        chk("p1_wait_ack", 32'(ioctl_wait), 1);
        step();
        chk("p1_wait_ack2", 32'(ioctl_wait), 1);
        chk("p1_req_hold", 32'(port1_req), 1);
        port1_ack = 1'b1;
        step();
        chk("p1_wait_done", 32'(ioctl_wait), 0);

        // port2 write: s = 0x04001 -> a = 0x000002, s[14] = 1 -> ds = 2'b10
        drive(8'd0, 25'h14001, 8'h5A);
        step();
        ioctl_wr = 1'b0;
        step();
        chk("p2_req", 32'(port2_req), 1);
        chk("p2_req1_hold", 32'(port1_req), 1);
        chk("p2_a", 32'(port2_a), 32'h000002);
        chk("p2_ds", 32'(port2_ds), 32'b10);
        chk("p2_d", 32'(port2_d), 32'h5A5A);
        chk("p2_p1a_hold", 32'(port1_a), 32'h000001);
        port2_ack = 1'b1;
        step();
        chk("p2_wait_done", 32'(ioctl_wait), 0);

        // sprite window base: s = 0 -> a = 0, ds = 2'b01
        drive(8'd0, 25'h10000, 8'h3F);
        step();
        ioctl_wr = 1'b0;
        step();
        chk("p2b_req", 32'(port2_req), 0);
        chk("p2b_a", 32'(port2_a), 0);
        chk("p2b_ds", 32'(port2_ds), 32'b01);
        port2_ack = 1'b0;
        step();
        chk("p2b_wait_done", 32'(ioctl_wait), 0);

        // on-chip ROM write just past the sprite window
        drive(8'd0, 25'h1C005, 8'h12);
        #1 chk("dl_wait_evt", 32'(ioctl_wait), 0);
        step();
        ioctl_wr = 1'b0;
        chk("dl_wr_hi", 32'(dl_wr), 1);
        chk("dl_wait", 32'(ioctl_wait), 0);
        step();
        chk("dl_wr_lo", 32'(dl_wr), 0);
        chk("dl_reqs", {30'd0, port2_req, port1_req}, 32'b01);

        // CPU_END itself is not port1
        drive(8'd0, 25'h0A000, 8'h34);
        step();
        ioctl_wr = 1'b0;
        chk("cpuend_dlwr", 32'(dl_wr), 1);
        step();
        step();
        chk("cpuend_reqs", {30'd0, port2_req, port1_req}, 32'b01);

        // DIP switches
        drive(8'd254, 25'd1, 8'h3C);
        step();
        ioctl_wr = 1'b0;
        chk("dip1", 32'(dip_sw1), 32'h3C);
        chk("dip_dlwr", 32'(dl_wr), 0);
        step();
        drive(8'd254, 25'd9, 8'h77);
        step();
        ioctl_wr = 1'b0;
        step();
        chk("dip9_sw1", 32'(dip_sw1), 32'h3C);
        chk("dip9_sw0", 32'(dip_sw0), 0);
        drive(8'd254, 25'd0, 8'h81);
        step();
        ioctl_wr = 1'b0;
        chk("dip0", 32'(dip_sw0), 32'h81);
        step();

        // second strobe while waiting for ack is dropped
        drive(8'd0, 25'h00010, 8'h11);
        step();
        ioctl_wr = 1'b0;
        step();
        chk("ovr_req", 32'(port1_req), 0);
        drive(8'd0, 25'h00020, 8'h22);
        step();
        ioctl_wr = 1'b0;
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_a_hold", 32'(port1_a), 32'h000008);
        chk("ovr_d_hold", 32'(port1_d), 32'h1111);
        step();
        step();
        chk("ovr_req_hold", 32'(port1_req), 0);
        port1_ack = 1'b0;
        step();
        chk("ovr_wait_done", 32'(ioctl_wait), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_req_final", 32'(port1_req), 0);

        // reset while waiting for ack
        drive(8'd0, 25'h10004, 8'h44);
        step();
        ioctl_wr = 1'b0;
        step();
        chk("rmid_req2", 32'(port2_req), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        port1_ack = 1'b0; port2_ack = 1'b0;
        chk("rmid_reqs", {30'd0, port2_req, port1_req}, 0);
        chk("rmid_wait", 32'(ioctl_wait), 0);
        chk("rmid_ovr", 32'(overrun), 0);
        chk("rmid_p2a", 32'(port2_a), 0);
        step();
        chk("rmid_req2_quiet", 32'(port2_req), 0);
        drive(8'd0, 25'h00005, 8'h99);
        step();
        ioctl_wr = 1'b0;
        step();
        chk("rfresh_req1", 32'(port1_req), 1);
        chk("rfresh_a", 32'(port1_a), 32'h000002);
        chk("rfresh_ds", 32'(port1_ds), 32'b10);
        chk("rfresh_d", 32'(port1_d), 32'h9999);
        port1_ack = 1'b1;
        step();
        chk("rfresh_wait", 32'(ioctl_wait), 0);

        // download inactive: strobes ignored
        ioctl_download = 1'b0;
        drive(8'd0, 25'h00003, 8'h55);
        #1 chk("nodl_wait", 32'(ioctl_wait), 0);
        step();
        ioctl_wr = 1'b0;
        step();
        chk("nodl_req1", 32'(port1_req), 1);
        drive(8'd0, 25'h1C005, 8'h55);
        step();
        ioctl_wr = 1'b0;
        chk("nodl_dlwr", 32'(dl_wr), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
